// File: rtl/calc_pkg.sv
// Shared types for the calculator/scan block: op codes, FSM states and the
// op-select priority decoder.
package calc_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MULT, OP_SQ} op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Square wins over multiply, which wins over subtract, which wins over add.
  function automatic op_e decode_op(input logic add, input logic sub,
                                    input logic mult, input logic sq);
    if (sq)        return OP_SQ;
    else if (mult) return OP_MULT;
    else if (sub)  return OP_SUB;
    else if (add)  return OP_ADD;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver: prescaler, scan index, active-low anode
// decode and nibble select. CALC_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module seg_scan_driver
  import calc_pkg::*;
#(
  parameter int RES_W    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RES_W-1:0]  result,
  output logic [DIGITS-1:0] an,
  output logic [NIBBLE-1:0] digit
);

  localparam int SHOWN = NIBBLE * DIGITS;
  localparam int RAW_W = (RES_W > SHOWN) ? RES_W : SHOWN;
  localparam int PAD_W = ((RAW_W + NIBBLE - 1) / NIBBLE) * NIBBLE;
  localparam int PSW   = $clog2(SCAN_DIV + 1);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PSW-1:0]   pre;
  logic [IW-1:0]    idx;
  logic [PAD_W-1:0] padded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PSW'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      pre <= pre + PSW'(1);
    end
  end

  // Zero-extend so nibbles above the result width read as 0.
  always_comb begin
    padded = '0;
    padded[RES_W-1:0] = result;
  end

  assign digit = padded[int'(idx)*NIBBLE +: NIBBLE];

`ifdef CALC_LEADING_ZERO_BLANK_EN
  int  top_nib;
  logic blank;

  always_comb begin
    top_nib = 0;
    for (int i = 1; i < PAD_W / NIBBLE; i++) begin
      if (padded[i*NIBBLE +: NIBBLE] != '0) top_nib = i;
    end
  end

  assign blank = int'(idx) > top_nib;

  always_comb begin
    an = '1;
    if (!blank) an[idx] = 1'b0;
  end
`else
  always_comb begin
    an = '1;
    an[idx] = 1'b0;
  end
`endif

endmodule

// File: rtl/calc_scan_mux.sv
// Registered calculator (add/sub/shift-add mult/square) feeding a scanning hex
// display. Define CALC_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module calc_scan_mux
  import calc_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               op_add,
  input  logic               op_sub,
  input  logic               op_mult,
  input  logic               op_sq,
  input  logic               go,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] result,
  output logic               neg,
  output logic [DIGITS-1:0]  an,
  output logic [NIBBLE-1:0]  digit
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_e          state;
  op_e             op_r;
  op_e             req_op;
  logic [RW-1:0]   mcand;
  logic [RW-1:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            commit;
  logic            neg_pend;
  logic            accept;

  assign req_op = decode_op(op_add, op_sub, op_mult, op_sq);
  assign accept = go && (req_op != OP_NONE) && (state != CALC);

  // The final value lands in acc as CALC ends; commit publishes it one cycle
  // later, so result/valid appear at edge 2 for add/sub and WIDTH+1 for mult/sq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_r     <= OP_NONE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      commit   <= 1'b0;
      neg_pend <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= '0;
      neg      <= 1'b0;
    end else begin
      if (commit) begin
        result <= acc;
        neg    <= neg_pend;
        valid  <= 1'b1;
        commit <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_r     <= req_op;
            mcand    <= RW'(a);
            mplier   <= (req_op == OP_SQ) ? a : b;
            acc      <= '0;
            neg_pend <= 1'b0;
            cnt      <= CW'(WIDTH);
            valid    <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          case (op_r)
            OP_ADD: begin
              acc    <= mcand + RW'(mplier);
              state  <= DONE;
              busy   <= 1'b0;
              commit <= 1'b1;
            end
            OP_SUB: begin
              if (RW'(mplier) > mcand) begin
                acc      <= RW'(mplier) - mcand;
                neg_pend <= 1'b1;
              end else begin
                acc <= mcand - RW'(mplier);
              end
              state  <= DONE;
              busy   <= 1'b0;
              commit <= 1'b1;
            end
            default: begin
              // One partial product per cycle, LSB of the multiplier first.
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt - CW'(1);
              if (cnt == CW'(1)) begin
                state  <= DONE;
                busy   <= 1'b0;
                commit <= 1'b1;
              end
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  seg_scan_driver #(
    .RES_W   (RW),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .result(result),
    .an    (an),
    .digit (digit)
  );

endmodule

// File: tb/tb_calc_scan_mux.sv
// Scoreboard bench for calc_scan_mux (WIDTH=4, DIGITS=4, SCAN_DIV=4); honours
// CALC_LEADING_ZERO_BLANK_EN for the expected anode pattern.
module tb_calc_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       op_add, op_sub, op_mult, op_sq, go;
  logic       busy, valid, neg;
  logic [7:0] result;
  logic [3:0] an;
  logic [3:0] digit;

  typedef struct packed {
    logic [7:0] res;
    logic       neg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  logic valid_q;

  always #5 clk = ~clk;

  calc_scan_mux #(.WIDTH(4), .DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .op_add(op_add), .op_sub(op_sub), .op_mult(op_mult), .op_sq(op_sq),
    .go(go), .busy(busy), .valid(valid), .result(result), .neg(neg),
    .an(an), .digit(digit)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Pops the scoreboard on every rising valid seen between clock edges.
  task automatic monitor_loop();
    exp_t e;
    valid_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid_q = 1'b0;
      end else begin
        if (valid && !valid_q) begin
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_valid: got result 0x%0h with no pending operation", result);
          end else begin
            e = sb.pop_front();
            check_output("sb_result", 32'(result), 32'(e.res));
            check_output("sb_neg", 32'(neg), 32'(e.neg));
          end
        end
        valid_q = valid;
      end
    end
  endtask

  // sel = {sq, mult, sub, add}; poke pulses an add request while busy.
  task automatic apply_stimulus(input string name, input logic [3:0] av, input logic [3:0] bv,
                                input logic [3:0] sel, input logic [7:0] exp_res,
                                input logic exp_neg, input int exp_lat, input int exp_busy,
                                input bit poke);
    int lat;
    int bc;
    sb.push_back('{res: exp_res, neg: exp_neg});
    a = av; b = bv;
    {op_sq, op_mult, op_sub, op_add} = sel;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    {op_sq, op_mult, op_sub, op_add} = 4'b0000;
    a = ~av; b = ~bv;
    check_output({name, "_busy_at_go"}, 32'(busy), 32'd1);
    check_output({name, "_valid_drop"}, 32'(valid), 32'd0);
    lat = 0;
    bc = busy ? 1 : 0;
    while (!valid && lat < 20) begin
      if (poke && lat == 1) begin
        go = 1'b1; op_add = 1'b1; a = 4'd1; b = 4'd1;
      end
      @(posedge clk); #1;
      go = 1'b0; op_add = 1'b0;
      lat++;
      if (busy) bc++;
    end
    check_output({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] exp_an [4];
    logic [3:0] exp_dig [4];
    logic [3:0] prev_an;
    int         w;

    rst_n = 1'b0;
    a = '0; b = '0;
    op_add = 0; op_sub = 0; op_mult = 0; op_sq = 0; go = 0;

    fork
      monitor_loop();
      begin
        #2;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(valid), 32'd0);
        check_output("rst_result", 32'(result), 32'd0);
        check_output("rst_neg", 32'(neg), 32'd0);
        check_output("rst_an", 32'(an), 32'b1110);
        check_output("rst_digit", 32'(digit), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        apply_stimulus("add", 4'd9, 4'd7, 4'b0001, 8'h10, 1'b0, 2, 1, 1'b0);

        // A go with no operation selected must be ignored.
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check_output("nop_go_busy", 32'(busy), 32'd0);
        check_output("nop_go_valid", 32'(valid), 32'd1);
        check_output("nop_go_result", 32'(result), 32'h10);

        apply_stimulus("sub_neg", 4'd3, 4'd5, 4'b0010, 8'h02, 1'b1, 2, 1, 1'b0);
        apply_stimulus("sub_pos", 4'd5, 4'd3, 4'b0010, 8'h02, 1'b0, 2, 1, 1'b0);
        apply_stimulus("mult", 4'd15, 4'd15, 4'b0100, 8'hE1, 1'b0, 5, 4, 1'b1);
        apply_stimulus("prio_sq", 4'd6, 4'd1, 4'b1001, 8'h24, 1'b0, 5, 4, 1'b0);

        // Scan of result 0x24: sync to the start of the anode-0 slot.
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_dig = '{4'h4, 4'h2, 4'h0, 4'h0};
`ifdef CALC_LEADING_ZERO_BLANK_EN
        exp_an[2] = 4'b1111;
        exp_an[3] = 4'b1111;
`endif
        w = 0;
        prev_an = an;
        @(posedge clk); #1;
        while (!(an == 4'b1110 && prev_an != 4'b1110) && w < 40) begin
          prev_an = an;
          @(posedge clk); #1;
          w++;
        end
        if (w >= 40) begin
          checks++;
          fails++;
          $display("[TB] FAIL scan_sync: an=%b never entered slot 0 within 40 cycles", an);
        end
        for (int s = 0; s < 4; s++) begin
          for (int c = 0; c < 4; c++) begin
            check_output($sformatf("scan_an_s%0d_c%0d", s, c), 32'(an), 32'(exp_an[s]));
            check_output($sformatf("scan_digit_s%0d_c%0d", s, c), 32'(digit), 32'(exp_dig[s]));
            @(posedge clk); #1;
          end
        end
        check_output("scan_wrap_an", 32'(an), 32'b1110);

        // Reset during cycle 2 of a multiply.
        a = 4'd13; b = 4'd11; op_mult = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; op_mult = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
        end
        check_output("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_result", 32'(result), 32'd0);
        check_output("midrst_valid", 32'(valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_neg", 32'(neg), 32'd0);
        check_output("midrst_an", 32'(an), 32'b1110);
        check_output("midrst_digit", 32'(digit), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        apply_stimulus("post_rst_mult", 4'd7, 4'd3, 4'b0100, 8'h15, 1'b0, 5, 4, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
      end
    join_any
    disable fork;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
